rf_wb_arbiter: RTL and testbench

//  Shares the register file's single write port (a3/wd3/we3) among N_REQ write-back sources (ALU, load unit, multi-cycle mul/div).

---
 rtl/rf_wb_pkg.sv | 21 ++
 rtl/rf_wb_arbiter_if.sv | 29 ++
 rtl/rr_picker.sv | 28 ++
 rtl/rf_wb_arbiter.sv | 106 ++++++++++
 tb/tb_rf_wb_arbiter.sv | 168 ++++++++++++++++
 5 files changed

// File: rtl/rf_wb_pkg.sv
// Shared constants, types and helpers for the register-file write-back arbiter.
package rf_wb_pkg;

    localparam int XLEN      = 32;
    localparam int REG_AW    = 5;
    localparam int NUM_REGS  = 2 ** REG_AW;
    localparam int N_REQ_DEF = 3;

    typedef struct packed {
        logic [REG_AW-1:0] rd;
        logic [XLEN-1:0]   data;
    } wb_req_t;

    typedef logic [NUM_REGS-1:0] reg_mask_t;

    // Round-robin successor of grant index g among n requesters.
    function automatic int unsigned ptr_next(input int unsigned g, input int unsigned n);
        return (g + 1 >= n) ? 0 : g + 1;
    endfunction

endpackage

// File: rtl/rf_wb_arbiter_if.sv
// Write-back request bus and register-file write port of the arbiter.
interface rf_wb_arbiter_if #(
    parameter int N_REQ  = rf_wb_pkg::N_REQ_DEF,
    parameter int XLEN   = rf_wb_pkg::XLEN,
    parameter int REG_AW = rf_wb_pkg::REG_AW
);
    localparam int NREGS = 2 ** REG_AW;

    logic [N_REQ-1:0]        req_valid;
    logic [N_REQ*REG_AW-1:0] req_rd;
    logic [N_REQ*XLEN-1:0]   req_data;
    logic [N_REQ-1:0]        req_ready;
    logic                    rf_we;
    logic [REG_AW-1:0]       rf_a;
    logic [XLEN-1:0]         rf_wd;
    logic [NREGS-1:0]        pend_mask;

    // Requester side (write-back sources plus register-file / hazard consumers).
    modport master (
        output req_valid, req_rd, req_data,
        input  req_ready, rf_we, rf_a, rf_wd, pend_mask
    );

    modport slave (
        input  req_valid, req_rd, req_data,
        output req_ready, rf_we, rf_a, rf_wd, pend_mask
    );

endinterface

// File: rtl/rr_picker.sv
// Combinational rotating-priority picker: first valid index at or after ptr_i, modulo N.
module rr_picker #(
    parameter int N  = 3,
    parameter int PW = 2
) (
    input  logic [N-1:0]  valid_i,
    input  logic [PW-1:0] ptr_i,
    output logic [N-1:0]  grant_o
);

    always_comb begin
        logic found;
        int   idx;
        grant_o = '0;
        found   = 1'b0;
        idx     = 0;
        for (int k = 0; k < N; k++) begin
            idx = (int'(ptr_i) + k) % N;
            for (int i = 0; i < N; i++) begin
                if (!found && (idx == i) && valid_i[i]) begin
                    grant_o[i] = 1'b1;
                    found      = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/rf_wb_arbiter.sv
// Round-robin arbiter sharing the register-file write port among write-back sources.
// Define RF_WB_ARB_FIXED_PRIO_EN for fixed priority (lowest index wins, no rr_ptr).
module rf_wb_arbiter #(
    parameter int N_REQ  = rf_wb_pkg::N_REQ_DEF,
    parameter int XLEN   = rf_wb_pkg::XLEN,
    parameter int REG_AW = rf_wb_pkg::REG_AW
) (
    input  logic           clk,
    input  logic           rst_n,
    rf_wb_arbiter_if.slave bus
);
    import rf_wb_pkg::*;

    localparam int PW    = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int NREGS = 2 ** REG_AW;

    logic [N_REQ-1:0]  grant;
    logic [PW-1:0]     pick_ptr;
    logic              gnt_any;
    logic [REG_AW-1:0] sel_rd;
    logic [XLEN-1:0]   sel_data;

    logic              rf_we_q, rf_we_d;
    logic [REG_AW-1:0] rf_a_q,  rf_a_d;
    logic [XLEN-1:0]   rf_wd_q, rf_wd_d;
    logic [NREGS-1:0]  pend;

    rr_picker #(.N(N_REQ), .PW(PW)) u_picker (
        .valid_i (bus.req_valid),
        .ptr_i   (pick_ptr),
        .grant_o (grant)
    );

    always_comb begin
        gnt_any  = |grant;
        sel_rd   = '0;
        sel_data = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (grant[i]) begin
                sel_rd   = bus.req_rd[i*REG_AW +: REG_AW];
                sel_data = bus.req_data[i*XLEN +: XLEN];
            end
        end
    end

`ifdef RF_WB_ARB_FIXED_PRIO_EN
    assign pick_ptr = '0;
`else
    logic [PW-1:0] rr_ptr_q, rr_ptr_d, gnt_idx;

    always_comb begin
        gnt_idx = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (grant[i]) gnt_idx = PW'(i);
        end
        rr_ptr_d = rr_ptr_q;
        if (gnt_any) rr_ptr_d = PW'(ptr_next(32'(gnt_idx), N_REQ));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rr_ptr_q <= '0;
        else        rr_ptr_q <= rr_ptr_d;
    end

    assign pick_ptr = rr_ptr_q;
`endif

    // x0 requests are accepted but never reach the register file.
    always_comb begin
        rf_we_d = gnt_any && (sel_rd != '0);
        rf_a_d  = rf_a_q;
        rf_wd_d = rf_wd_q;
        if (rf_we_d) begin
            rf_a_d  = sel_rd;
            rf_wd_d = sel_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rf_we_q <= 1'b0;
            rf_a_q  <= '0;
            rf_wd_q <= '0;
        end else begin
            rf_we_q <= rf_we_d;
            rf_a_q  <= rf_a_d;
            rf_wd_q <= rf_wd_d;
        end
    end

    always_comb begin
        pend = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (bus.req_valid[i]) pend[bus.req_rd[i*REG_AW +: REG_AW]] = 1'b1;
        end
        if (rf_we_q) pend[rf_a_q] = 1'b1;
        pend[0] = 1'b0;
    end

    assign bus.req_ready = grant;
    assign bus.rf_we     = rf_we_q;
    assign bus.rf_a      = rf_a_q;
    assign bus.rf_wd     = rf_wd_q;
    assign bus.pend_mask = pend;

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Scoreboard bench for rf_wb_arbiter: directed vectors, queued expected writes, negedge monitor.
module tb_rf_wb_arbiter;
    import rf_wb_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    wb_req_t          exp_q[$];
    logic [XLEN-1:0]  rfm [NUM_REGS];

    rf_wb_arbiter_if #(.N_REQ(3), .XLEN(XLEN), .REG_AW(REG_AW)) bus ();

    rf_wb_arbiter #(.N_REQ(3), .XLEN(XLEN), .REG_AW(REG_AW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Monitor: register file commits on the falling edge; every write must match the queue head.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && bus.rf_we === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write: got a=%0d wd=0x%0h expected no write", bus.rf_a, bus.rf_wd);
            end else begin
                wb_req_t e;
                e = exp_q.pop_front();
                chk("wr_addr", 64'(bus.rf_a), 64'(e.rd));
                chk("wr_data", 64'(bus.rf_wd), 64'(e.data));
            end
            rfm[bus.rf_a] = bus.rf_wd;
        end
    end

    // Called one time unit after a posedge; drives a cycle, checks ready/pend_mask, queues the write.
    task automatic cyc(input logic [2:0] v,
                       input logic [4:0] r0, input logic [4:0] r1, input logic [4:0] r2,
                       input logic [31:0] d0, input logic [31:0] d1, input logic [31:0] d2,
                       input logic [2:0] exp_rdy, input logic [31:0] exp_pm, input bit push = 1'b1);
        logic [4:0]  rd [3];
        logic [31:0] dd [3];
        rd[0] = r0; rd[1] = r1; rd[2] = r2;
        dd[0] = d0; dd[1] = d1; dd[2] = d2;
        bus.req_valid = v;
        bus.req_rd    = {r2, r1, r0};
        bus.req_data  = {d2, d1, d0};
        #1;
        chk("req_ready", 64'(bus.req_ready), 64'(exp_rdy));
        chk("pend_mask", 64'(bus.pend_mask), 64'(exp_pm));
        for (int i = 0; i < 3; i++) begin
            if (push && exp_rdy[i] && rd[i] != 5'd0) exp_q.push_back('{rd: rd[i], data: dd[i]});
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input logic [31:0] exp_pm);
        cyc(3'b000, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0, 3'b000, exp_pm);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not reach the end");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [2:0]  g3 [6];
        logic [31:0] pm_after;
        for (int r = 0; r < NUM_REGS; r++) rfm[r] = '0;
        rst_n         = 1'b0;
        bus.req_valid = '0;
        bus.req_rd    = '0;
        bus.req_data  = '0;
        #1;
        chk("rst_rf_we", 64'(bus.rf_we), 64'd0);
        chk("rst_rf_a", 64'(bus.rf_a), 64'd0);
        chk("rst_rf_wd", 64'(bus.rf_wd), 64'd0);
        chk("rst_pend", 64'(bus.pend_mask), 64'd0);
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Single request to x5
        cyc(3'b001, 5'd5, 5'd0, 5'd0, 32'hDEADBEEF, 32'h0, 32'h0, 3'b001, 32'h20);
        chk("single_we", 64'(bus.rf_we), 64'd1);
        idle(32'h20);
        chk("x5_after", 64'(rfm[5]), 64'hDEADBEEF);
        idle(32'h0);

        // Reset while a write sits in the output stage
        cyc(3'b001, 5'd5, 5'd0, 5'd0, 32'h0BADF00D, 32'h0, 32'h0, 3'b001, 32'h20, 1'b0);
        bus.req_valid = '0;
        chk("pre_rst_we", 64'(bus.rf_we), 64'd1);
        #1 rst_n = 1'b0;
        #1;
        chk("midrst_we", 64'(bus.rf_we), 64'd0);
        chk("midrst_a", 64'(bus.rf_a), 64'd0);
        chk("midrst_wd", 64'(bus.rf_wd), 64'd0);
        @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("x5_kept", 64'(rfm[5]), 64'hDEADBEEF);

        // All three requesters continuously valid
`ifdef RF_WB_ARB_FIXED_PRIO_EN
        g3 = '{3'b001, 3'b001, 3'b001, 3'b001, 3'b001, 3'b001};
        pm_after = 32'h400;
`else
        g3 = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};
        pm_after = 32'h1000;
`endif
        for (int c = 0; c < 6; c++)
            cyc(3'b111, 5'd10, 5'd11, 5'd12, 32'hA0, 32'hA1, 32'hA2, g3[c], 32'h1C00);
        idle(pm_after);

        // x0 write is accepted but dropped
        cyc(3'b010, 5'd0, 5'd0, 5'd0, 32'h0, 32'h1234, 32'h0, 3'b010, 32'h0);
        chk("x0_no_we", 64'(bus.rf_we), 64'd0);
        idle(32'h0);

        // Lone req2 write, leaves rr_ptr at 0
        cyc(3'b100, 5'd0, 5'd0, 5'd20, 32'h0, 32'h0, 32'h55, 3'b100, 32'h0010_0000);
        idle(32'h0010_0000);

        // pend_mask tracks queued and in-flight destinations
        cyc(3'b101, 5'd3, 5'd0, 5'd7, 32'h33, 32'h0, 32'h77, 3'b001, 32'h88);
        cyc(3'b100, 5'd0, 5'd0, 5'd7, 32'h0, 32'h0, 32'h77, 3'b100, 32'h88);
        idle(32'h80);
        idle(32'h0);
        chk("x3_val", 64'(rfm[3]), 64'h33);
        chk("x7_val", 64'(rfm[7]), 64'h77);

        // Two writers to x9: later grant wins
        cyc(3'b011, 5'd9, 5'd9, 5'd0, 32'h1, 32'h2, 32'h0, 3'b001, 32'h200);
        cyc(3'b010, 5'd0, 5'd9, 5'd0, 32'h0, 32'h2, 32'h0, 3'b010, 32'h200);
        idle(32'h200);
        idle(32'h0);
        chk("x9_race", 64'(rfm[9]), 64'h2);

        // Search wraps from rr_ptr=2 back to requester 0
        cyc(3'b011, 5'd1, 5'd2, 5'd0, 32'h11, 32'h22, 32'h0, 3'b001, 32'h6);
        cyc(3'b010, 5'd0, 5'd2, 5'd0, 32'h0, 32'h22, 32'h0, 3'b010, 32'h6);
        idle(32'h4);
        idle(32'h0);

        repeat (2) @(posedge clk);
        chk("queue_empty", 64'(exp_q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
